// File: rtl/dsp_add_arbiter_if.sv
// Handshake bundle between requesters/consumer/shared adder and dsp_add_arbiter.
// The master side is everything outside the arbiter; the slave side is the arbiter itself.
interface dsp_add_arbiter_if #(
    parameter int width   = 48,
    parameter int num_req = 4,
    parameter int id_w    = $clog2(num_req)
);
    logic [num_req-1:0]       req_valid;
    logic [num_req*width-1:0] req_a;
    logic [num_req*width-1:0] req_b;
    logic [num_req-1:0]       req_ready;
    logic [width-1:0]         add_a;
    logic [width-1:0]         add_b;
    logic [width-1:0]         add_y;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [width-1:0]         resp_y;
    logic [id_w-1:0]          resp_id;

    modport master (
        output req_valid, req_a, req_b, add_y, resp_ready,
        input  req_ready, add_a, add_b, resp_valid, resp_y, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, add_y, resp_ready,
        output req_ready, add_a, add_b, resp_valid, resp_y, resp_id
    );
endinterface

// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter sharing one combinational adder among num_req requesters;
// the winner's sum is captured in a single result register tagged with its id.
module dsp_add_arbiter #(
    parameter int width   = 48,
    parameter int num_req = 4,
    parameter int id_w    = $clog2(num_req)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    dsp_add_arbiter_if.slave  bus
);

    logic [id_w-1:0]  r_rr_ptr;
    logic             r_resp_valid;
    logic [width-1:0] r_resp_y;
    logic [id_w-1:0]  r_resp_id;

    logic [id_w-1:0]  w_cand [num_req];
    logic [id_w-1:0]  w_gnt;
    logic             w_can_issue;
    logic             w_issue;
    logic [id_w:0]    w_gnt_inc;

    // Candidate k is the requester index k places after the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < num_req; gi++) begin : g_cand
            logic [id_w:0] w_sum;
            assign w_sum = {1'b0, r_rr_ptr} + (id_w+1)'(gi);
            assign w_cand[gi] = (w_sum >= (id_w+1)'(num_req))
                              ? id_w'(w_sum - (id_w+1)'(num_req))
                              : id_w'(w_sum);
        end
    endgenerate

    // Scan from the far end so the candidate closest to the pointer wins.
    always_comb begin
        w_gnt = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            if (bus.req_valid[w_cand[k]]) begin
                w_gnt = w_cand[k];
            end
        end
    end

    assign w_can_issue = !r_resp_valid || bus.resp_ready;
    assign w_issue     = !i_reset && w_can_issue && (|bus.req_valid);
    assign w_gnt_inc   = {1'b0, w_gnt} + (id_w+1)'(1);

    assign bus.req_ready  = w_issue ? (num_req'(1) << w_gnt) : '0;
    assign bus.add_a      = w_issue ? bus.req_a[w_gnt*width +: width] : '0;
    assign bus.add_b      = w_issue ? bus.req_b[w_gnt*width +: width] : '0;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_y     = r_resp_y;
    assign bus.resp_id    = r_resp_id;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rr_ptr     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_y     <= '0;
            r_resp_id    <= '0;
        end else if (w_issue) begin
            r_resp_y     <= bus.add_y;
            r_resp_id    <= w_gnt;
            r_resp_valid <= 1'b1;
            r_rr_ptr     <= (w_gnt_inc == (id_w+1)'(num_req)) ? '0 : w_gnt_inc[id_w-1:0];
        end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Self-checking bench for dsp_add_arbiter: vector table plus hand-written corner sequences,
// with a result scoreboard fed at grant time and drained when the consumer accepts.
module tb_dsp_add_arbiter;

    logic clk;
    logic rst;

    dsp_add_arbiter_if #(.width(8),  .num_req(4)) bus8  ();
    dsp_add_arbiter_if #(.width(48), .num_req(2)) bus48 ();

    dsp_add_arbiter #(.width(8), .num_req(4)) u_dut8 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus8)
    );

    dsp_add_arbiter #(.width(48), .num_req(2)) u_dut48 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus48)
    );

    // Shared adder models: plain modulo sums.
    assign bus8.add_y  = bus8.add_a + bus8.add_b;
    assign bus48.add_y = bus48.add_a + bus48.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_ready;
        logic        exp_rvalid;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] y;
    } exp_t;

    vec_t vecs [15];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic rrdy);
        bus8.req_valid  = v;
        bus8.req_a      = a;
        bus8.req_b      = b;
        bus8.resp_ready = rrdy;
    endtask

    // Push the expected result for the grant the bench predicts this cycle.
    task automatic push_exp(input logic [3:0] gnt, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [7:0] sa;
        logic [7:0] sb;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
                sa   = a[i*8 +: 8];
                sb   = b[i*8 +: 8];
                e.id = 2'(i);
                e.y  = sa + sb;
                sb_q.push_back(e);
            end
        end
    endtask

    // Scoreboard drain: one line per consumed result.
    always @(negedge clk) begin
        if (!rst && bus8.resp_valid && bus8.resp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got id=%0d y=%0h expected no result",
                         bus8.resp_id, bus8.resp_y);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("resp id=%0d y=%02h (expected id=%0d y=%02h)",
                         bus8.resp_id, bus8.resp_y, e.id, e.y);
                chk("sb_resp_id", 64'(bus8.resp_id), 64'(e.id));
                chk("sb_resp_y",  64'(bus8.resp_y),  64'(e.y));
            end
        end
    end

    initial begin
        // Requests 0..3: rows 1-2 single req 2, row 3 aligns pointer to 0,
        // rows 4-9 round robin, rows 10-12 pointer skip, rows 13-15 8-bit wrap.
        vecs[0]  = '{4'b0100, 32'h0010_0000, 32'h0005_0000, 4'b0100, 1'b0};
        vecs[1]  = '{4'b0000, 32'h0,         32'h0,         4'b0000, 1'b1};
        vecs[2]  = '{4'b1000, 32'h0700_0000, 32'h0100_0000, 4'b1000, 1'b0};
        vecs[3]  = '{4'b1111, 32'h0302_0100, 32'h0101_0101, 4'b0001, 1'b1};
        vecs[4]  = '{4'b1111, 32'h0302_0100, 32'h0101_0101, 4'b0010, 1'b1};
        vecs[5]  = '{4'b1111, 32'h0302_0100, 32'h0101_0101, 4'b0100, 1'b1};
        vecs[6]  = '{4'b1111, 32'h0302_0100, 32'h0101_0101, 4'b1000, 1'b1};
        vecs[7]  = '{4'b1111, 32'h0302_0100, 32'h0101_0101, 4'b0001, 1'b1};
        vecs[8]  = '{4'b1111, 32'h0302_0100, 32'h0101_0101, 4'b0010, 1'b1};
        vecs[9]  = '{4'b0001, 32'h0000_0020, 32'h0000_0030, 4'b0001, 1'b1};
        vecs[10] = '{4'b1001, 32'h4000_0020, 32'h0400_0030, 4'b1000, 1'b1};
        vecs[11] = '{4'b0001, 32'h0000_0020, 32'h0000_0030, 4'b0001, 1'b1};
        vecs[12] = '{4'b0001, 32'h0000_00FF, 32'h0000_0002, 4'b0001, 1'b1};
        vecs[13] = '{4'b0000, 32'h0,         32'h0,         4'b0000, 1'b1};
        vecs[14] = '{4'b0000, 32'h0,         32'h0,         4'b0000, 1'b0};

        rst = 1'b1;
        drive(4'b1111, 32'h0102_0304, 32'h0101_0101, 1'b1);
        bus48.req_valid  = 2'b00;
        bus48.req_a      = '0;
        bus48.req_b      = '0;
        bus48.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  64'(bus8.req_ready),  64'h0);
        chk("rst_resp_valid", 64'(bus8.resp_valid), 64'h0);
        chk("rst_resp_y",     64'(bus8.resp_y),     64'h0);
        chk("rst_resp_id",    64'(bus8.resp_id),    64'h0);
        chk("rst_add_a",      64'(bus8.add_a),      64'h0);
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].valid, vecs[i].a, vecs[i].b, 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", i),  64'(bus8.req_ready),  64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_resp_valid", i), 64'(bus8.resp_valid), 64'(vecs[i].exp_rvalid));
            if (vecs[i].exp_ready != 4'b0000) begin
                push_exp(vecs[i].exp_ready, vecs[i].a, vecs[i].b);
            end
        end

        // Backpressure: first result id 0 / 8'h15, then requests 1 and 3 stall.
        @(posedge clk); #1;
        drive(4'b0001, 32'h0000_0010, 32'h0000_0005, 1'b1);
        @(negedge clk);
        chk("bp_first_ready", 64'(bus8.req_ready), 64'h1);
        push_exp(4'b0001, 32'h0000_0010, 32'h0000_0005);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            drive(4'b1010, 32'h3300_1100, 32'h0300_0100, 1'b0);
            @(negedge clk);
            chk($sformatf("bp_stall%0d_ready", c), 64'(bus8.req_ready),  64'h0);
            chk($sformatf("bp_stall%0d_valid", c), 64'(bus8.resp_valid), 64'h1);
            chk($sformatf("bp_stall%0d_y", c),     64'(bus8.resp_y),     64'h15);
            chk($sformatf("bp_stall%0d_id", c),    64'(bus8.resp_id),    64'h0);
        end
        @(posedge clk); #1;
        bus8.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(bus8.req_ready), 64'b0010);
        push_exp(4'b0010, 32'h3300_1100, 32'h0300_0100);
        @(posedge clk); #1;
        drive(4'b1000, 32'h3300_1100, 32'h0300_0100, 1'b1);
        @(negedge clk);
        chk("bp_next_id", 64'(bus8.resp_id), 64'h1);
        chk("bp_next_ready", 64'(bus8.req_ready), 64'b1000);
        push_exp(4'b1000, 32'h3300_1100, 32'h0300_0100);
        @(posedge clk); #1;
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        @(posedge clk); #1;

        // Async reset with a pending, stalled result; pointer sits at 2 beforehand.
        drive(4'b0010, 32'h0000_0500, 32'h0000_0600, 1'b0);
        @(negedge clk);
        chk("ar_grant", 64'(bus8.req_ready), 64'b0010);
        push_exp(4'b0010, 32'h0000_0500, 32'h0000_0600);
        @(posedge clk); #1;
        drive(4'b1010, 32'h0000_0500, 32'h0000_0600, 1'b0);
        @(negedge clk);
        chk("ar_pending_valid", 64'(bus8.resp_valid), 64'h1);
        chk("ar_pending_ready", 64'(bus8.req_ready),  64'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_resp_valid", 64'(bus8.resp_valid), 64'h0);
        chk("ar_resp_y",     64'(bus8.resp_y),     64'h0);
        chk("ar_req_ready",  64'(bus8.req_ready),  64'h0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus8.resp_ready = 1'b1;
        #1;
        chk("ar_first_grant", 64'(bus8.req_ready), 64'b0010);
        push_exp(4'b0010, 32'h0000_0500, 32'h0000_0600);
        @(posedge clk); #1;
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        @(posedge clk); #1;

        // 48-bit wrap on the second instance.
        bus48.req_valid = 2'b01;
        bus48.req_a     = {48'h0, 48'hFFFF_FFFF_FFFF};
        bus48.req_b     = {48'h0, 48'h1};
        @(negedge clk);
        chk("w48_ready", 64'(bus48.req_ready), 64'h1);
        @(posedge clk); #1;
        bus48.req_valid = 2'b00;
        @(negedge clk);
        chk("w48_valid", 64'(bus48.resp_valid), 64'h1);
        chk("w48_y",     64'(bus48.resp_y),     64'h0);
        chk("w48_id",    64'(bus48.resp_id),    64'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dsp_add_arbiter.md
Name: dsp_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `dsp_add` instance among `num_req` requesters.
- Each requester offers an operand pair with a valid/ready handshake.
- The arbiter steers the winner's operands onto the shared adder ports and captures the sum in a result register tagged with the requester id.
- Sits between multiple datapath clients and a single DSP48E2 adder, so adds need not be replicated across DSP slices.

Parameters:
- width, 48, operand/result width; legal range 1..48, matching the shared adder.
- num_req, 4, number of requesters; legal range 2..16.
- id_w, $clog2(num_req), width of the requester id tag.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  num_req  bit i: requester i presents an operand pair.
- req_a  input  num_req*width  flattened operand A; slice i at [i*width +: width].
- req_b  input  num_req*width  flattened operand B; same slicing.
- req_ready  output  num_req  one-hot grant/accept; bit i high = requester i's pair taken this cycle.
- add_a  output  width  operand A driven to the shared adder.
- add_b  output  width  operand B driven to the shared adder.
- add_y  input  width  combinational sum returned from the shared adder (PREG=0).
- resp_valid  output  1  result register holds a valid sum.
- resp_ready  input  1  consumer accepts the result this cycle.
- resp_y  output  width  registered sum.
- resp_id  output  id_w  index of the requester that produced resp_y.

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, resp_valid=0, resp_y=0, resp_id=0. req_ready reads 0 while reset is high. add_a and add_b read 0.
- Issue condition: can_issue = !resp_valid || resp_ready. A full result register that is being drained in the same cycle counts as free.
- Arbitration (combinational):
  - When can_issue and any req_valid is set, the winner g is the first valid index scanning rr_ptr, rr_ptr+1, …, wrapping modulo num_req.
  - req_ready[g]=1 and all other bits are 0.
  - With no issue, req_ready=0.
  - req_ready may depend on the same-cycle req_valid.
- Adder steering: add_a and add_b equal req_a/req_b slice g when granted, otherwise 0. No operand register; the adder path is combinational within the issue cycle.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters hold valid and data stable until their transfer; the arbiter never drops an accepted pair.
- On transfer (next edge):
  - resp_y <= add_y; resp_id <= g; resp_valid <= 1.
  - rr_ptr <= (g+1) mod num_req.
  - Latency is exactly 1 cycle from accept to resp_valid.
- Drain with no new issue: resp_valid <= 0; resp_y and resp_id hold their last values.
- Stall: while resp_valid && !resp_ready, no grant is issued, resp_y and resp_id are stable, and rr_ptr is stable.
- Simultaneous drain and issue: the new result replaces the old in the same edge, giving back-to-back throughput of 1 add/cycle.
- rr_ptr changes only on a transfer. An idle cycle does not advance it.
- Fairness: with all requesters continuously valid and resp_ready=1, grants rotate 0,1,…,num_req-1,0. Every requester is served within num_req issues.
- Arithmetic: sum is modulo 2^width as returned by the adder. The arbiter performs no extension or saturation.
- Reset mid-operation: a pending result is discarded (resp_valid=0 immediately) and rr_ptr returns to 0. Requesters must re-present after reset.

Test Plan:
1. Single request:
   - Stimulus: num_req=4, width=8; only req 2 valid with a=8'h10, b=8'h05.
   - Required: req_ready=4'b0100 in cycle 0; next cycle resp_valid=1, resp_y=8'h15, resp_id=2; rr_ptr=3.
2. Round-robin:
   - Stimulus: all 4 valid continuously with a=i, b=1; resp_ready=1.
   - Required: resp_id sequence 0,1,2,3,0,1 on consecutive cycles; resp_y = i+1 each; no idle cycles.
3. Backpressure:
   - Stimulus: resp_ready=0 after the first result (id 0, y=8'h15); requests 1 and 3 valid.
   - Required: req_ready=0 for 3 cycles; resp_y/resp_id stable at 8'h15/0. Raising resp_ready gives grant to 1 in that same cycle and resp_id=1 next cycle.
4. Wrap-around arithmetic:
   - Stimulus: width=8, a=8'hFF, b=8'h02.
   - Required: resp_y=8'h01.
   - Stimulus: width=48, a=48'hFFFF_FFFF_FFFF, b=1.
   - Required: resp_y=0.
5. Pointer skip:
   - Stimulus: rr_ptr=1 (after a grant to 0); only req 0 and 3 valid.
   - Required: grant 3, then grant 0; rr_ptr goes 0→1.
6. Async reset:
   - Stimulus: assert reset mid-cycle while resp_valid=1, resp_ready=0.
   - Required: resp_valid=0, resp_y=0, req_ready=0 without waiting for a clock edge; after release, first grant is lowest valid index from 0.
